// File: rtl/lsu_pkg.sv
// lsu_pkg: shared funct3 codes, FSM state type and request legality helper for the LSU
package lsu_pkg;
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        return we ? (f3 == F3_SB || f3 == F3_SH || f3 == F3_SW)
                  : (f3 == F3_LB || f3 == F3_LH || f3 == F3_LW || f3 == F3_LBU || f3 == F3_LHU);
    endfunction
endpackage

// File: rtl/lsu_load_fmt.sv
// lsu_load_fmt: selects the addressed byte/halfword lane of a memory word and extends it
//   mem_rdata : raw 32-bit memory word
//   funct3    : load size/sign code
//   addr      : byte offset within the word
//   rdata     : right-aligned, sign- or zero-extended load result
module lsu_load_fmt
    import lsu_pkg::*;
(
    input  logic [31:0] mem_rdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr,
    output logic [31:0] rdata
);
    logic [7:0]  b;
    logic [15:0] h;
    assign b = mem_rdata[{addr, 3'b000} +: 8];
    assign h = addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    always_comb
        rdata = funct3 == F3_LB  ? {{24{b[7]}}, b} :
                funct3 == F3_LH  ? {{16{h[15]}}, h} :
                funct3 == F3_LBU ? {24'b0, b} :
                funct3 == F3_LHU ? {16'b0, h} : mem_rdata;
endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: RV32I load/store unit controller, one request in flight, IDLE->ACCESS->RESP
//   clk, rst_n                      : clock, async active-low reset
//   req_valid/ready/we/funct3/addr/wdata : core request channel
//   rsp_valid/ready/rdata/err       : core response channel, held until consumed
//   mem_addr/wdata/wr/be/rdata      : word-indexed data memory port (combinational read)
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int MEM_AW = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [11:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_wr,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata
);
    state_t              state;
    logic                we_q;
    logic [2:0]          f3_q;
    logic [MEM_AW+1:0]   addr_q;
    logic [31:0]         wdata_q;
    logic [31:0]         fmt;
    logic                req_ok;
    logic [3:0]          be;

    // Size is encoded in funct3[1:0] for both loads and stores once funct3 is known legal.
    always_comb
        req_ok = f3_legal(req_we, req_funct3)
              && !(req_funct3[1:0] == 2'b01 && req_addr[0])
              && !(req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00)
              && (req_addr >> (MEM_AW + 2)) == '0;

    always_comb
        be = f3_q[1:0] == 2'b00 ? 4'b0001 << addr_q[1:0] :
             f3_q[1:0] == 2'b01 ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;

    assign req_ready = state == ST_IDLE;
    assign rsp_valid = state == ST_RESP;
    assign mem_wr    = state == ST_ACCESS && we_q;
    assign mem_be    = mem_wr ? be : 4'b0000;
    assign mem_addr  = 12'(addr_q[MEM_AW+1:2]);

    always_comb
        mem_wdata = f3_q[1:0] == 2'b00 ? {4{wdata_q[7:0]}} :
                    f3_q[1:0] == 2'b01 ? {2{wdata_q[15:0]}} : wdata_q;

    lsu_load_fmt u_fmt (
        .mem_rdata (mem_rdata),
        .funct3    (f3_q),
        .addr      (addr_q[1:0]),
        .rdata     (fmt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            we_q      <= 1'b0;
            f3_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (state == ST_IDLE && req_valid) begin
            we_q      <= req_we;
            f3_q      <= req_funct3;
            addr_q    <= req_addr[MEM_AW+1:0];
            wdata_q   <= req_wdata;
            rsp_rdata <= '0;
            rsp_err   <= !req_ok;
            state     <= req_ok ? ST_ACCESS : ST_RESP;
        end else if (state == ST_ACCESS) begin
            rsp_rdata <= we_q ? '0 : fmt;
            state     <= ST_RESP;
        end else if (state == ST_RESP && rsp_ready) begin
            state     <= ST_IDLE;
        end
    end
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: scoreboard bench for lsu_ctrl with a behavioural data memory
module tb_lsu_ctrl;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_err, mem_wr;
    logic [31:0] rsp_rdata, mem_wdata, mem_rdata;
    logic [11:0] mem_addr;
    logic [3:0]  mem_be;

    always #5 clk = ~clk;

    lsu_ctrl #(.MEM_AW(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr), .mem_be(mem_be),
        .mem_rdata(mem_rdata)
    );

    typedef struct { logic [31:0] rdata; logic err; } exp_t;
    exp_t        sb[$];
    logic [31:0] mem[0:4095];
    logic [31:0] ref_mem[0:4095];
    int          checks = 0, errors = 0, wr_count = 0;

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
        for (int i = 0; i < 4; i++) if (be[i]) o[8*i +: 8] = n[8*i +: 8];
        return o;
    endfunction

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_wr) begin
        mem[mem_addr] <= merge(mem[mem_addr], mem_wdata, mem_be);
        wr_count++;
    end

    function automatic logic tb_legal(input logic we, input logic [2:0] f3, input logic [31:0] a);
        logic ok;
        ok = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if ((f3 == 3'd1 || f3 == 3'd5) && a[0]) ok = 1'b0;
        if (f3 == 3'd2 && a[1:0] != 2'b00) ok = 1'b0;
        if (a[31:10] != 22'd0) ok = 1'b0;
        return ok;
    endfunction

    function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [1:0] a);
        case (f3)
            3'd0:    return 4'b0001 << a;
            3'd1:    return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] exp_wd(input logic [2:0] f3, input logic [31:0] w);
        case (f3)
            3'd0:    return {w[7:0], w[7:0], w[7:0], w[7:0]};
            3'd1:    return {w[15:0], w[15:0]};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] word, input logic [1:0] a);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(word >> (8 * a));
        h = 16'(word >> (16 * a[1]));
        case (f3)
            3'd0:    return 32'($signed(b));
            3'd4:    return 32'(b);
            3'd1:    return 32'($signed(h));
            3'd5:    return 32'(h);
            default: return word;
        endcase
    endfunction

    task automatic push(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        exp_t e;
        e.err = !tb_legal(we, f3, a);
        e.rdata = '0;
        if (!e.err && we)
            ref_mem[a[9:2]] = merge(ref_mem[a[9:2]], exp_wd(f3, wd), exp_be(f3, a[1:0]));
        else if (!e.err)
            e.rdata = exp_load(f3, ref_mem[a[9:2]], a[1:0]);
        sb.push_back(e);
    endtask

    task automatic do_req(input string name, input logic we, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, input int hold);
        exp_t e;
        int   wc0;
        logic ok;
        ok = tb_legal(we, f3, a);
        push(we, f3, a, wd);
        wc0 = wr_count;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        // junk with valid held high must be ignored until back in IDLE
        req_we = 1'($urandom_range(0, 1)); req_funct3 = 3'($urandom);
        req_addr = $urandom_range(0, 1023); req_wdata = $urandom;
        if (ok) begin
            checks++;
            if (rsp_valid !== 1'b0 || mem_wr !== we)
                $display("FAIL %s access: rsp_valid=%b mem_wr=%b expected 0 %b", name, rsp_valid, mem_wr, we);
            if (rsp_valid !== 1'b0 || mem_wr !== we) errors++;
            if (we) begin
                checks++;
                if (mem_be !== exp_be(f3, a[1:0]) || mem_wdata !== exp_wd(f3, wd) || mem_addr !== {4'b0, a[9:2]}) begin
                    errors++;
                    $display("FAIL %s mem: addr=%h be=%b wdata=%h expected %h %b %h", name, mem_addr, mem_be,
                             mem_wdata, {4'b0, a[9:2]}, exp_be(f3, a[1:0]), exp_wd(f3, wd));
                end
            end else begin
                checks++;
                if (mem_be !== 4'b0000) begin
                    errors++;
                    $display("FAIL %s load_be: be=%b expected 0000", name, mem_be);
                end
            end
            @(posedge clk); #1;
        end
        checks++;
        if (rsp_valid !== 1'b1 || mem_wr !== 1'b0 || mem_be !== 4'b0000) begin
            errors++;
            $display("FAIL %s latency: rsp_valid=%b mem_wr=%b be=%b expected 1 0 0000", name, rsp_valid, mem_wr, mem_be);
        end
        e = sb.pop_front();
        checks++;
        if (rsp_rdata !== e.rdata || rsp_err !== e.err) begin
            errors++;
            $display("FAIL %s rsp: rdata=%h err=%b expected %h %b", name, rsp_rdata, rsp_err, e.rdata, e.err);
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            checks++;
            if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_rdata !== e.rdata || rsp_err !== e.err) begin
                errors++;
                $display("FAIL %s hold%0d: valid=%b ready=%b rdata=%h err=%b expected 1 0 %h %b",
                         name, i, rsp_valid, req_ready, rsp_rdata, rsp_err, e.rdata, e.err);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0; req_valid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || wr_count - wc0 != int'(ok && we)) begin
            errors++;
            $display("FAIL %s done: valid=%b ready=%b writes=%0d expected 0 1 %0d",
                     name, rsp_valid, req_ready, wr_count - wc0, int'(ok && we));
        end
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== '0 || rsp_err !== 1'b0 ||
            mem_wr !== 1'b0 || mem_be !== '0 || mem_addr !== '0 || mem_wdata !== '0) begin
            errors++;
            $display("FAIL reset: ready=%b valid=%b rdata=%h err=%b wr=%b be=%b addr=%h wdata=%h expected 1 0 0 0 0 0 0 0",
                     req_ready, rsp_valid, rsp_rdata, rsp_err, mem_wr, mem_be, mem_addr, mem_wdata);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_store_word();
        do_req("sw_10", 1'b1, F3_SW, 32'h10, 32'hDEADBEEF, 0);
    endtask

    task automatic test_byte();
        do_req("sb_13", 1'b1, F3_SB, 32'h13, 32'h000000A5, 0);
        do_req("lb_13", 1'b0, F3_LB, 32'h13, 32'h0, 0);
        do_req("lbu_13", 1'b0, F3_LBU, 32'h13, 32'h0, 1);
        do_req("sb_10", 1'b1, F3_SB, 32'h10, 32'h0000007E, 0);
        do_req("lb_10", 1'b0, F3_LB, 32'h10, 32'h0, 0);
    endtask

    task automatic test_half();
        do_req("sh_22", 1'b1, F3_SH, 32'h22, 32'h00008001, 0);
        do_req("lh_22", 1'b0, F3_LH, 32'h22, 32'h0, 0);
        do_req("lhu_22", 1'b0, F3_LHU, 32'h22, 32'h0, 0);
        do_req("sh_20", 1'b1, F3_SH, 32'h20, 32'h12347FFF, 0);
        do_req("lw_20", 1'b0, F3_LW, 32'h20, 32'h0, 0);
    endtask

    task automatic test_errors();
        do_req("err_lw06", 1'b0, F3_LW, 32'h06, 32'h0, 0);
        do_req("err_lh03", 1'b0, F3_LH, 32'h03, 32'h0, 0);
        do_req("err_sw400", 1'b1, F3_SW, 32'h400, 32'hCAFEF00D, 0);
        do_req("err_f3_011", 1'b0, 3'b011, 32'h0, 32'h0, 0);
        do_req("err_sf3_100", 1'b1, 3'b100, 32'h8, 32'h55, 0);
        do_req("ok_lw_3fc", 1'b0, F3_LW, 32'h3FC, 32'h0, 0);
    endtask

    task automatic test_backpressure();
        do_req("bp_lw10", 1'b0, F3_LW, 32'h10, 32'h0, 5);
        do_req("bp_lbu11", 1'b0, F3_LBU, 32'h11, 32'h0, 0);
    endtask

    task automatic test_back_to_back();
        localparam int N = 24;
        int   issued = 0, got = 0, last_acc = 0;
        logic last_err = 1'b0, we;
        logic [2:0] f3;
        logic [31:0] a;
        exp_t e;
        rsp_ready = 1'b1;
        for (int c = 0; c < 200 && got < N; c++) begin
            if (rsp_valid) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_extra: unexpected response rdata=%h err=%b", rsp_rdata, rsp_err);
                end else begin
                    e = sb.pop_front();
                    if (rsp_rdata !== e.rdata || rsp_err !== e.err) begin
                        errors++;
                        $display("FAIL b2b_rsp%0d: rdata=%h err=%b expected %h %b", got, rsp_rdata, rsp_err, e.rdata, e.err);
                    end
                end
                got++;
            end
            if (req_ready && issued < N) begin
                if (issued > 0) begin
                    checks++;
                    if (c - last_acc != (last_err ? 2 : 3)) begin
                        errors++;
                        $display("FAIL b2b_gap%0d: cycles=%0d expected %0d", issued, c - last_acc, last_err ? 2 : 3);
                    end
                end
                we = 1'($urandom_range(0, 1));
                f3 = we ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 5));
                if ($urandom_range(0, 7) == 0) f3 = 3'b011;
                a = $urandom_range(0, 1023);
                if ($urandom_range(0, 3) != 0) a = f3[1] ? {a[31:2], 2'b00} : f3[0] ? {a[31:1], 1'b0} : a;
                if ($urandom_range(0, 9) == 0) a = a | 32'h400;
                req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = $urandom;
                push(we, f3, a, req_wdata);
                last_err = !tb_legal(we, f3, a);
                last_acc = c;
                issued++;
            end else begin
                req_valid = !req_ready && 1'($urandom_range(0, 1));
                req_we = 1'($urandom_range(0, 1)); req_funct3 = 3'($urandom);
                req_addr = $urandom; req_wdata = $urandom;
            end
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        checks++;
        if (got != N || sb.size() != 0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_count: responses=%0d left=%0d ready=%b expected %0d 0 1", got, sb.size(), req_ready, N);
        end
    endtask

    task automatic test_reset_midflight();
        int wc0;
        wc0 = wr_count;
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_SW; req_addr = 32'h40; req_wdata = 32'h12345678;
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++;
        if (mem_wr !== 1'b1) begin
            errors++;
            $display("FAIL rst_access: mem_wr=%b expected 1", mem_wr);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (mem_wr !== 1'b0 || mem_be !== 4'b0000 || rsp_valid !== 1'b0 || req_ready !== 1'b1 || mem_addr !== '0) begin
            errors++;
            $display("FAIL rst_async: wr=%b be=%b valid=%b ready=%b addr=%h expected 0 0000 0 1 000",
                     mem_wr, mem_be, rsp_valid, req_ready, mem_addr);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
                errors++;
                $display("FAIL rst_idle%0d: valid=%b ready=%b expected 0 1", i, rsp_valid, req_ready);
            end
        end
        checks++;
        if (mem[16] !== ref_mem[16] || wr_count != wc0) begin
            errors++;
            $display("FAIL rst_mem: word=%h writes=%0d expected %h 0", mem[16], wr_count - wc0, ref_mem[16]);
        end
        do_req("rst_lw40", 1'b0, F3_LW, 32'h40, 32'h0, 0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        test_reset();
        test_store_word();
        test_byte();
        test_half();
        test_errors();
        test_backpressure();
        test_back_to_back();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
